adder_pipe: RTL



---
 rtl/adder_pipe_pkg.sv | 45 ++++
 rtl/adder_pipe_acc_bank.sv | 47 ++++
 rtl/adder_pipe.sv | 120 ++++++++++++
 3 files changed

// File: rtl/adder_pipe_pkg.sv
// adder_pipe_pkg: shared types and the overflow-aware add used by the adder_pipe datapath.
// Latency: n/a (types and a combinational function only).
// Backpressure: n/a.
// Contents: mode_e, add_res_t, add_ovf(), and the ADDER_PIPE_S1_T stage-1 beat typedef macro.
// Build option: ADDER_PIPE_SAT_EN makes add_ovf clamp overflowing results to all-ones.
package adder_pipe_pkg;

   typedef enum logic {
      MODE_ADD   = 1'b0,
      MODE_ACCUM = 1'b1
   } mode_e;

   // Widest datapath add_ovf can serve; callers zero-extend into it.
   localparam int MAX_W = 64;

   typedef struct packed {
      logic [MAX_W-1:0] sum;
      logic             ovf;
   } add_res_t;

   // acc + addend, judged against a width-bit result. Any bit at or above
   // 'width' counts as overflow, which covers both the single carry of a
   // plain add and the two-bit carry of accumulate-plus-sum.
   function automatic add_res_t add_ovf(input logic [MAX_W-1:0] acc,
                                        input logic [MAX_W:0]   addend,
                                        input int unsigned      width);
      logic [MAX_W+1:0] t;
      logic [MAX_W+1:0] mask;
      add_res_t         res;
      t        = {2'b00, acc} + {1'b0, addend};
      mask     = {(MAX_W+2){1'b1}} >> (MAX_W + 2 - width);
      res.ovf  = |(t & ~mask);
      res.sum  = MAX_W'(t & mask);
`ifdef ADDER_PIPE_SAT_EN
      if (res.ovf) begin
         res.sum = MAX_W'(mask);
      end
`endif
      return res;
   endfunction

endpackage

// Stage-1 beat: raw a+b with its carry, plus the steering fields.
`define ADDER_PIPE_S1_T(W, CW) struct packed { logic [(W):0] sum; logic [(CW)-1:0] ch; adder_pipe_pkg::mode_e mode; logic clr; }

// File: rtl/adder_pipe_acc_bank.sv
// adder_pipe_acc_bank: CHANNELS x WIDTH accumulator register file.
// Latency: combinational read, write lands on the next clock edge.
// Backpressure: none; the caller gates wr_en to real pipeline transfers.
// Ports: clk, rst (async active-high, clears all entries), rd_ch -> rd_dat,
//        wr_en/wr_ch/wr_dat write port. Out-of-range channels read 0 and are never written.
module adder_pipe_acc_bank #(
   parameter int WIDTH    = 32,
   parameter int CHANNELS = 4,
   parameter int CH_W     = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [CH_W-1:0]  rd_ch,
   output logic [WIDTH-1:0] rd_dat,
   input  logic             wr_en,
   input  logic [CH_W-1:0]  wr_ch,
   input  logic [WIDTH-1:0] wr_dat
);

   logic [WIDTH-1:0] acc [CHANNELS];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < CHANNELS; i++) begin
            acc[i] <= '0;
         end
      end else begin
         for (int i = 0; i < CHANNELS; i++) begin
            if (wr_en && (wr_ch == CH_W'(i))) begin
               acc[i] <= wr_dat;
            end
         end
      end
   end

   // Decoded compare rather than a direct index so a non-power-of-2 bank
   // never indexes past its last entry.
   always_comb begin
      rd_dat = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         if (rd_ch == CH_W'(i)) begin
            rd_dat = acc[i];
         end
      end
   end

endmodule

// File: rtl/adder_pipe.sv
// adder_pipe: two-stage unsigned adder / per-channel accumulator with valid/ready on both sides.
// Latency: 2 cycles from input acceptance to o_valid; sustains 1 beat/cycle.
// Backpressure: i_ready low holds the output stage; o_ready drops only when both stages are full.
// Ports: i_clk, i_rst (async active-high); input beat i_valid/o_ready with i_a, i_b, i_ch,
//        i_mode (0 ADD, 1 ACCUM), i_clr (ACCUM load); output beat o_valid/i_ready with o_sum, o_ch, o_ovf.
// Build option: ADDER_PIPE_SAT_EN clamps overflowing results, and the stored accumulator, to all-ones.
// WIDTH may not exceed adder_pipe_pkg::MAX_W.
module adder_pipe
   import adder_pipe_pkg::*;
#(
   parameter  int WIDTH    = 32,
   parameter  int CHANNELS = 4,
   localparam int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_valid,
   output logic             o_ready,
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   input  logic [CH_W-1:0]  i_ch,
   input  logic             i_mode,
   input  logic             i_clr,
   output logic             o_valid,
   input  logic             i_ready,
   output logic [WIDTH-1:0] o_sum,
   output logic [CH_W-1:0]  o_ch,
   output logic             o_ovf
);

   typedef `ADDER_PIPE_S1_T(WIDTH, CH_W) s1_t;

   s1_t              s1_q;
   logic             s1_vld;
   logic             s2_adv;
   logic             s1_adv;
   logic             ch_ok;
   logic             accumulate;
   logic [WIDTH-1:0] acc_rd;
   logic [WIDTH-1:0] acc_sel;
   logic             acc_we;
   add_res_t         res;
   logic             unused_res;
   logic [WIDTH-1:0] s2_sum_d;
   logic             s2_ovf_d;

   assign s2_adv  = !o_valid || i_ready;
   assign s1_adv  = s1_vld && s2_adv;
   assign o_ready = !s1_vld || s2_adv;

   assign ch_ok      = int'(s1_q.ch) < CHANNELS;
   assign accumulate = (s1_q.mode == MODE_ACCUM) && !s1_q.clr;

   // ADD and ACCUM-load both reduce to 0 + s1 sum, so one adder covers all modes.
   assign acc_sel = accumulate ? acc_rd : '0;
   assign res     = add_ovf(MAX_W'(acc_sel), (MAX_W+1)'(s1_q.sum), WIDTH);

   // Bits above WIDTH are always zero; folded here so nothing dangles.
   assign unused_res = ^res.sum;

   always_comb begin
      s2_sum_d = res.sum[WIDTH-1:0];
      s2_ovf_d = res.ovf;
      if (!ch_ok) begin
         // No such accumulator: pass the raw sum through and flag it.
         s2_sum_d = s1_q.sum[WIDTH-1:0];
         s2_ovf_d = 1'b1;
      end
   end

   // The write and the S2 load share one edge, so a following beat on the
   // same channel already reads the updated value: no forwarding needed.
   assign acc_we = s1_adv && (s1_q.mode == MODE_ACCUM) && ch_ok;

   adder_pipe_acc_bank #(
      .WIDTH    (WIDTH),
      .CHANNELS (CHANNELS),
      .CH_W     (CH_W)
   ) u_acc_bank (
      .clk    (i_clk),
      .rst    (i_rst),
      .rd_ch  (s1_q.ch),
      .rd_dat (acc_rd),
      .wr_en  (acc_we),
      .wr_ch  (s1_q.ch),
      .wr_dat (s2_sum_d)
   );

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         s1_vld <= 1'b0;
         s1_q   <= '0;
      end else if (o_ready) begin
         s1_vld <= i_valid;
         if (i_valid) begin
            s1_q <= '{sum:  {1'b0, i_a} + {1'b0, i_b},
                      ch:   i_ch,
                      mode: mode_e'(i_mode),
                      clr:  i_clr};
         end
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         o_valid <= 1'b0;
         o_sum   <= '0;
         o_ch    <= '0;
         o_ovf   <= 1'b0;
      end else if (s2_adv) begin
         o_valid <= s1_vld;
         if (s1_vld) begin
            o_sum <= s2_sum_d;
            o_ch  <= s1_q.ch;
            o_ovf <= s2_ovf_d;
         end
      end
   end

endmodule
